vending_mac_multi: RTL
======================

Name: vending_mac_multi

Overview:
Parametrised successor to the single-product vending FSM.
- Accepts nickel, dime and quarter pulses into a saturating credit register.
- Vends one of NUM_ITEMS products at a programmable PRICE and tracks per-item stock.
- Returns change one coin per cycle, largest coin first, and supports cancel/refund.
- Sits between the coin-acceptor front end and the dispenser/changer actuators.

Parameters:
PRICE, 25, item price in cents; multiple of 5, 5..MAX_CREDIT.
MAX_CREDIT, 95, highest credit held; multiple of 5.
CW, 8, credit width; must hold MAX_CREDIT+25.
NUM_ITEMS, 4, number of products, 1..16.
SW, $clog2(NUM_ITEMS), width of item select (min 1).
STOCK_W, 4, per-item stock counter width.
INIT_STOCK, 15, stock loaded at reset/restock; must be ≤ 2^STOCK_W-1.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low; 0 = reset.
n  in  1  nickel (5) pulse, one cycle per coin.
d  in  1  dime (10) pulse.
q  in  1  quarter (25) pulse.
sel  in  SW  item select, sampled with vend_req.
vend_req  in  1  vend request pulse.
cancel  in  1  refund request pulse.
restock  in  1  reload all stock to INIT_STOCK; honoured in IDLE only.
dispense  out  1  one-cycle vend strobe.
item_out  out  SW  item being dispensed; valid with dispense, else 0.
change_valid  out  1  a change coin is presented this cycle.
change_coin  out  2  01 = nickel, 10 = dime, 11 = quarter; 00 when not valid.
coin_reject  out  1  one-cycle pulse: a coin was refused.
vend_err  out  1  one-cycle pulse: vend refused.
credit  out  CW  current credit in cents.
sold_out  out  NUM_ITEMS  bit i = 1 when stock[i] == 0.
busy  out  1  high in DISPENSE or CHANGE.

Behaviour:
- Reset (reset = 0, async):
  - state = IDLE; credit = 0; every stock[i] = INIT_STOCK.
  - All pulse outputs, item_out and change_coin = 0; sold_out = 0 when INIT_STOCK > 0.
- Outputs are registered and take effect on the edge after the cause.
- States and transitions:
  - IDLE: credit == 0. Any accepted coin → ACCUM.
  - ACCUM:
    - Coins add to credit.
    - vend_req, when credit ≥ PRICE and stock[sel] > 0 → DISPENSE.
    - cancel → CHANGE.
  - DISPENSE (exactly 1 cycle):
    - dispense = 1, item_out = sel latched at request.
    - credit -= PRICE; stock[sel] -= 1.
    - Next state: CHANGE if remaining credit > 0, else IDLE.
  - CHANGE: each cycle emits the largest coin ≤ credit (25/10/5) and subtracts it. When credit reaches 0 → IDLE on the same edge.
- Coins:
  - Simultaneous n/d/q in one cycle sum (max 40).
  - If credit + sum > MAX_CREDIT, the whole sum is refused: coin_reject = 1, credit unchanged.
  - Coins arriving while busy are refused with coin_reject.
- vend_req refusal: vend_req with credit < PRICE, stock[sel] == 0, or state IDLE → vend_err = 1 for one cycle; credit and state unchanged.
- Priority within one cycle in ACCUM:
  - cancel beats vend_req.
  - vend_req is evaluated against credit before that cycle's coins.
  - Coins in the same cycle as an accepted vend_req are refused.
- vend_req or cancel while busy: ignored, no vend_err.
- restock: in IDLE, all stock is set to INIT_STOCK next cycle; ignored in any other state.
- Stock never underflows. sold_out is combinational from the stock registers.
- Reset asserted mid-DISPENSE or mid-CHANGE aborts immediately: credit is lost, stock is reinitialised.

Test Plan:
1. Reset → credit = 0, dispense/change_valid/busy = 0, sold_out = 0000; hold 3 cycles and confirm no change.
2. q pulse, then vend_req with sel = 2 → dispense = 1 with item_out = 2 for one cycle; credit = 0; no change_valid; sold_out[2] stays 0 (stock 14).
3. n+d+q in one cycle (credit 40), then vend_req with sel = 1 → dispense, then change_coin = 10, then 01 on consecutive cycles; then IDLE with credit 0.
4. d (credit 10), then vend_req → vend_err pulse, credit stays 10. Then cancel → one cycle change_coin = 10, then IDLE.
5. Drain item 0 with 15 vends (q each) → sold_out[0] = 1. 16th q + vend_req with sel = 0 → vend_err, credit stays 25. restock refused in ACCUM; after cancel and refund, restock → sold_out[0] = 0.
6. Credit 90 (3q + d + n), then q → coin_reject, credit stays 90. vend_req → dispense, change sequence 25, 25, 10, 5. Assert reset during the second change cycle → all outputs 0 asynchronously, credit 0.

Source files
------------

// File: rtl/vending_mac_multi.sv
// Multi-product vending controller: coin credit, per-item stock, vend strobe and
// largest-coin-first change / refund, with all actuator-facing pulses registered.
//
// state      | meaning
// S_IDLE     | credit is zero, waiting for a coin; restock accepted here only
// S_ACCUM    | credit held, accepting coins, vend or cancel
// S_DISPENSE | one-cycle vend strobe; price and stock already deducted
// S_CHANGE   | returning remaining credit one coin per cycle
module vending_mac_multi #(
  parameter int PRICE      = 25,
  parameter int MAX_CREDIT = 95,
  parameter int CW         = 8,
  parameter int NUM_ITEMS  = 4,
  parameter int SW         = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 n,
  input  logic                 d,
  input  logic                 q,
  input  logic [SW-1:0]        sel,
  input  logic                 vend_req,
  input  logic                 cancel,
  input  logic                 restock,
  output logic                 dispense,
  output logic [SW-1:0]        item_out,
  output logic                 change_valid,
  output logic [1:0]           change_coin,
  output logic                 coin_reject,
  output logic                 vend_err,
  output logic [CW-1:0]        credit,
  output logic [NUM_ITEMS-1:0] sold_out,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACCUM    = 2'd1,
    S_DISPENSE = 2'd2,
    S_CHANGE   = 2'd3
  } state_t;

  localparam logic [CW:0]        MAX_X   = (CW+1)'(MAX_CREDIT);
  localparam logic [CW:0]        N_X     = (CW+1)'(5);
  localparam logic [CW:0]        D_X     = (CW+1)'(10);
  localparam logic [CW:0]        Q_X     = (CW+1)'(25);
  localparam logic [CW-1:0]      PRICE_C = CW'(PRICE);
  localparam logic [CW-1:0]      C5      = CW'(5);
  localparam logic [CW-1:0]      C10     = CW'(10);
  localparam logic [CW-1:0]      C25     = CW'(25);
  localparam logic [STOCK_W-1:0] INIT_C  = STOCK_W'(INIT_STOCK);
  localparam logic [STOCK_W-1:0] ONE_S   = STOCK_W'(1);

  state_t               state_q, state_d;
  logic [CW-1:0]        credit_q, credit_d;
  logic [STOCK_W-1:0]   stock_q [NUM_ITEMS];
  logic [STOCK_W-1:0]   stock_d [NUM_ITEMS];
  logic                 dispense_q, dispense_d;
  logic [SW-1:0]        item_out_q, item_out_d;
  logic                 change_valid_q, change_valid_d;
  logic [1:0]           change_coin_q, change_coin_d;
  logic                 coin_reject_q, coin_reject_d;
  logic                 vend_err_q, vend_err_d;

  logic                 coin_any;
  logic [CW:0]          coin_sum;
  logic [CW:0]          credit_sum;
  logic                 coin_fits;
  logic                 coin_refuse;
  logic                 sel_ok;
  logic                 can_vend;
  logic [CW-1:0]        chg_val;
  logic [1:0]           chg_code;

  always_comb begin
    coin_sum = '0;
    if (n) coin_sum = coin_sum + N_X;
    if (d) coin_sum = coin_sum + D_X;
    if (q) coin_sum = coin_sum + Q_X;
    coin_any   = n | d | q;
    credit_sum = {1'b0, credit_q} + coin_sum;
    coin_fits  = (credit_sum <= MAX_X);
    sel_ok     = (int'(sel) < NUM_ITEMS);
    can_vend   = sel_ok && (credit_q >= PRICE_C) && (stock_q[sel] != '0);
    // Largest coin not exceeding the remaining credit.
    if (credit_q >= C25) begin
      chg_val  = C25;
      chg_code = 2'b11;
    end else if (credit_q >= C10) begin
      chg_val  = C10;
      chg_code = 2'b10;
    end else begin
      chg_val  = C5;
      chg_code = 2'b01;
    end
  end

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    stock_d        = stock_q;
    dispense_d     = 1'b0;
    item_out_d     = '0;
    change_valid_d = 1'b0;
    change_coin_d  = 2'b00;
    coin_reject_d  = 1'b0;
    vend_err_d     = 1'b0;
    coin_refuse    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (restock) begin
          for (int i = 0; i < NUM_ITEMS; i++) stock_d[i] = INIT_C;
        end
        if (vend_req) vend_err_d = 1'b1;
      end
      S_ACCUM: begin
        if (cancel) begin
          coin_refuse = 1'b1;
          state_d     = S_CHANGE;
        end else if (vend_req) begin
          if (can_vend) begin
            coin_refuse     = 1'b1;
            credit_d        = credit_q - PRICE_C;
            stock_d[sel]    = stock_q[sel] - ONE_S;
            dispense_d      = 1'b1;
            item_out_d      = sel;
            state_d         = S_DISPENSE;
          end else begin
            vend_err_d = 1'b1;
          end
        end
      end
      S_DISPENSE: begin
        coin_refuse = 1'b1;
        state_d     = (credit_q != '0) ? S_CHANGE : S_IDLE;
      end
      S_CHANGE: begin
        coin_refuse    = 1'b1;
        change_valid_d = 1'b1;
        change_coin_d  = chg_code;
        credit_d       = credit_q - chg_val;
        if (credit_q == chg_val) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A refused coin batch leaves credit untouched; an accepted one adds in full.
    if (coin_any) begin
      if (coin_refuse || !coin_fits) begin
        coin_reject_d = 1'b1;
      end else begin
        credit_d = credit_sum[CW-1:0];
        if (state_q == S_IDLE) state_d = S_ACCUM;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      credit_q       <= '0;
      for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= INIT_C;
      dispense_q     <= 1'b0;
      item_out_q     <= '0;
      change_valid_q <= 1'b0;
      change_coin_q  <= 2'b00;
      coin_reject_q  <= 1'b0;
      vend_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      stock_q        <= stock_d;
      dispense_q     <= dispense_d;
      item_out_q     <= item_out_d;
      change_valid_q <= change_valid_d;
      change_coin_q  <= change_coin_d;
      coin_reject_q  <= coin_reject_d;
      vend_err_q     <= vend_err_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ITEMS; i++) sold_out[i] = (stock_q[i] == '0);
  end

  assign dispense     = dispense_q;
  assign item_out     = item_out_q;
  assign change_valid = change_valid_q;
  assign change_coin  = change_coin_q;
  assign coin_reject  = coin_reject_q;
  assign vend_err     = vend_err_q;
  assign credit       = credit_q;
  assign busy         = (state_q == S_DISPENSE) || (state_q == S_CHANGE);

endmodule
